// File: rtl/tx_audio_mem.sv
// Transmit audio sample memory: a circular word buffer fed by the host, drained one
// interleaved sample set per tx_avail_A strobe, with the frame trailer parsed after the last set.
module tx_audio_mem #(
  parameter int unsigned V_TX_CHANS = 4,
  parameter int unsigned ADDR_MSB   = 12
) (
  input  logic                         adc_clk,
  input  logic                         reset_n,
  input  logic [7:0]                   nsamps_A,
  input  logic                         wr_A,
  input  logic [15:0]                  wr_din_A,
  output logic                         wr_full_A,
  output logic [ADDR_MSB+1:0]          fill_A,
  input  logic                         tx_avail_A,
  output logic [V_TX_CHANS*48-1:0]     txn_dout_A,
  output logic                         txn_valid_A,
  output logic [47:0]                  ticks_A,
  output logic [15:0]                  buf_ctr_A,
  output logic                         frame_done_A,
  input  logic                         clr_err_A,
  output logic                         overflow_A,
  output logic                         underrun_A,
  output logic                         late_A,
  output logic                         seq_err_A
);

  localparam int unsigned AW    = ADDR_MSB + 1;
  localparam int unsigned LW    = ADDR_MSB + 2;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned NW    = 3 * V_TX_CHANS;
  localparam int unsigned OW    = V_TX_CHANS * 48;

  typedef enum logic [2:0] {S_IDLE, S_RD_SET, S_TRL_TS, S_TRL_CTR, S_DONE} state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_ram_q;
  logic [AW-1:0] r_waddr;
  logic [AW-1:0] r_rptr;
  logic [7:0]    r_count;
  logic [7:0]    r_nframe;
  logic [4:0]    r_idx;
  logic [15:0]   r_exp_ctr;
  logic [OW-1:0] r_shadow;
  logic          r_cap_set;
  logic          r_cap_ts;
  logic [4:0]    r_cap_idx;

  logic          w_wr_acc;
  logic          w_rd;
  logic [7:0]    w_nsamps;
  logic [7:0]    w_nframe;
  logic [LW-1:0] w_need;
  logic [LW-1:0] w_lvl_nxt;
  logic          w_ov_set;
  logic          w_ur_set;
  logic          w_late_set;
  logic          w_seq_set;
  logic [OW-1:0] w_shadow_nxt;

  assign w_wr_acc   = wr_A && !wr_full_A;
  assign w_rd       = (r_state == S_RD_SET) || (r_state == S_TRL_TS) || (r_state == S_TRL_CTR);
  assign w_nsamps   = (nsamps_A == 8'd0) ? 8'd1 : nsamps_A;
  assign w_nframe   = (r_count == 8'd0) ? w_nsamps : r_nframe;
  // The last set of a frame must also find its 4 trailer words already buffered.
  assign w_need     = LW'(NW) + ((r_count == w_nframe - 8'd1) ? LW'(4) : LW'(0));
  assign w_lvl_nxt  = fill_A + LW'(w_wr_acc) - LW'(w_rd);
  assign w_ov_set   = wr_A && wr_full_A;
  assign w_ur_set   = (r_state == S_IDLE) && tx_avail_A && (fill_A < w_need);
  assign w_late_set = (r_state != S_IDLE) && tx_avail_A;
  assign w_seq_set  = (r_state == S_DONE) && (r_ram_q != r_exp_ctr);

  // Word k of a set lands at bit k*16, i.e. channel k/3, field k%3.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (r_cap_set) begin
      for (int k = 0; k < NW; k++) begin
        if (r_cap_idx == 5'(k)) w_shadow_nxt[k*16 +: 16] = r_ram_q;
      end
    end
  end

  // Storage array, synchronous read, no reset.
  always_ff @(posedge adc_clk) begin
    if (w_wr_acc) r_mem[r_waddr] <= wr_din_A;
    r_ram_q <= r_mem[r_rptr];
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_waddr      <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_nframe     <= '0;
      r_idx        <= '0;
      r_exp_ctr    <= '0;
      r_shadow     <= '0;
      r_cap_set    <= 1'b0;
      r_cap_ts     <= 1'b0;
      r_cap_idx    <= '0;
      fill_A       <= '0;
      wr_full_A    <= 1'b0;
      txn_dout_A   <= '0;
      txn_valid_A  <= 1'b0;
      ticks_A      <= '0;
      buf_ctr_A    <= '0;
      frame_done_A <= 1'b0;
      overflow_A   <= 1'b0;
      underrun_A   <= 1'b0;
      late_A       <= 1'b0;
      seq_err_A    <= 1'b0;
    end else begin
      txn_valid_A  <= 1'b0;
      frame_done_A <= 1'b0;
      r_waddr      <= r_waddr + AW'(w_wr_acc);
      r_rptr       <= r_rptr + AW'(w_rd);
      fill_A       <= w_lvl_nxt;
      wr_full_A    <= (w_lvl_nxt == LW'(DEPTH));
      r_cap_set    <= (r_state == S_RD_SET);
      r_cap_ts     <= (r_state == S_TRL_TS);
      r_cap_idx    <= r_idx;
      r_shadow     <= w_shadow_nxt;

      // Whole set is published at once when its last word arrives.
      if (r_cap_set && (r_cap_idx == 5'(NW - 1))) begin
        txn_dout_A  <= w_shadow_nxt;
        txn_valid_A <= 1'b1;
      end
      if (r_cap_ts) begin
        case (r_cap_idx[1:0])
          2'd0:    ticks_A[15:0]  <= r_ram_q;
          2'd1:    ticks_A[31:16] <= r_ram_q;
          default: ticks_A[47:32] <= r_ram_q;
        endcase
      end

      overflow_A <= w_ov_set   ? 1'b1 : (clr_err_A ? 1'b0 : overflow_A);
      underrun_A <= w_ur_set   ? 1'b1 : (clr_err_A ? 1'b0 : underrun_A);
      late_A     <= w_late_set ? 1'b1 : (clr_err_A ? 1'b0 : late_A);
      seq_err_A  <= w_seq_set  ? 1'b1 : (clr_err_A ? 1'b0 : seq_err_A);

      case (r_state)
        S_IDLE: begin
          if (r_count == 8'd0) r_nframe <= w_nsamps;
          if (tx_avail_A) begin
            if (fill_A >= w_need) begin
              r_state <= S_RD_SET;
              r_idx   <= '0;
            end else begin
              txn_dout_A  <= '0;
              txn_valid_A <= 1'b1;
            end
          end
        end
        S_RD_SET: begin
          r_idx <= r_idx + 5'd1;
          if (r_idx == 5'(NW - 1)) begin
            r_idx   <= '0;
            r_count <= r_count + 8'd1;
            r_state <= (r_count + 8'd1 == r_nframe) ? S_TRL_TS : S_IDLE;
          end
        end
        S_TRL_TS: begin
          r_idx <= r_idx + 5'd1;
          if (r_idx == 5'd2) begin
            r_idx   <= '0;
            r_state <= S_TRL_CTR;
          end
        end
        S_TRL_CTR: r_state <= S_DONE;
        S_DONE: begin
          // Counter word is on the RAM output this cycle; resync the expectation to it.
          buf_ctr_A    <= r_ram_q;
          r_exp_ctr    <= r_ram_q + 16'd1;
          frame_done_A <= 1'b1;
          r_count      <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_audio_mem.sv
// Directed bench for tx_audio_mem: table of whole frames plus hand sequences for
// underrun, overflow, late strobes and reset in the middle of a set.
module tb_tx_audio_mem;

  localparam int unsigned DEPTH = 8192;

  logic         adc_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   nsamps_A = 8'd0;
  logic         wr_A = 1'b0;
  logic [15:0]  wr_din_A = 16'd0;
  logic         wr_full_A;
  logic [13:0]  fill_A;
  logic         tx_avail_A = 1'b0;
  logic [191:0] txn_dout_A;
  logic         txn_valid_A;
  logic [47:0]  ticks_A;
  logic [15:0]  buf_ctr_A;
  logic         frame_done_A;
  logic         clr_err_A = 1'b0;
  logic         overflow_A, underrun_A, late_A, seq_err_A;

  tx_audio_mem #(.V_TX_CHANS(4), .ADDR_MSB(12)) dut (
    .adc_clk(adc_clk), .reset_n(reset_n), .nsamps_A(nsamps_A), .wr_A(wr_A),
    .wr_din_A(wr_din_A), .wr_full_A(wr_full_A), .fill_A(fill_A), .tx_avail_A(tx_avail_A),
    .txn_dout_A(txn_dout_A), .txn_valid_A(txn_valid_A), .ticks_A(ticks_A),
    .buf_ctr_A(buf_ctr_A), .frame_done_A(frame_done_A), .clr_err_A(clr_err_A),
    .overflow_A(overflow_A), .underrun_A(underrun_A), .late_A(late_A), .seq_err_A(seq_err_A)
  );

  always #5 adc_clk = ~adc_clk;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int fd_cnt    = 0;

  always @(negedge adc_clk) begin
    if (txn_valid_A)  valid_cnt <= valid_cnt + 1;
    if (frame_done_A) fd_cnt    <= fd_cnt + 1;
  end

  typedef struct {
    logic [7:0]  nsamps;     // as driven (0 means 1)
    int          nsets;
    logic [15:0] base;       // data word i = base + i
    logic [15:0] ctr;        // trailer counter word
    logic [15:0] exp_ch0_i;  // last set, channel 0 I
    logic [15:0] exp_ch3_iq3;// last set, channel 3 iq3
    logic [47:0] exp_ticks;
    logic        exp_seq;
  } frame_t;

  frame_t vec [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err_A = 1'b1;
    tick();
    clr_err_A = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_A = 1'b1;
    wr_din_A = w;
    tick();
    wr_A = 1'b0;
  endtask

  // Pulse tx_avail_A for one cycle (cycle 0); return the cycle txn_valid_A is seen in.
  task automatic request(output int lat, output logic [191:0] dout);
    tx_avail_A = 1'b1;
    tick();
    tx_avail_A = 1'b0;
    lat = 1;
    dout = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge adc_clk);
      if (txn_valid_A) begin
        dout = txn_dout_A;
        break;
      end
      @(posedge adc_clk);
      lat++;
    end
    @(posedge adc_clk);
    #1;
  endtask

  task automatic wait_fd(input int start);
    int n;
    n = 0;
    while (fd_cnt == start && n < 60) begin
      tick();
      n++;
    end
    repeat (2) tick();
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    int lat, nw, fd0;
    logic [191:0] dout;
    nw = f.nsets * 12 + 3;
    nsamps_A = f.nsamps;
    for (int i = 0; i < nw; i++) write_word(f.base + 16'(i));
    write_word(f.ctr);
    fd0 = fd_cnt;
    for (int s = 0; s < f.nsets; s++) begin
      request(lat, dout);
      chk({tag, " latency"}, 64'(lat), 64'd14);
      repeat (30) tick();
    end
    wait_fd(fd0);
    chk({tag, " ch0 I"}, 64'(dout[15:0]), 64'(f.exp_ch0_i));
    chk({tag, " ch3 iq3"}, 64'(dout[191:176]), 64'(f.exp_ch3_iq3));
    chk({tag, " ticks"}, 64'(ticks_A), 64'(f.exp_ticks));
    chk({tag, " buf_ctr"}, 64'(buf_ctr_A), 64'(f.ctr));
    chk({tag, " seq_err"}, 64'(seq_err_A), 64'(f.exp_seq));
    chk({tag, " frame_done count"}, 64'(fd_cnt - fd0), 64'd1);
    chk({tag, " fill drained"}, 64'(fill_A), 64'd0);
  endtask

  initial begin
    int lat, v0, fd0;
    logic [191:0] dout;

    vec[0] = '{8'd2, 2, 16'h0001, 16'h001C, 16'h000D, 16'h0018, 48'h001B_001A_0019, 1'b1};
    vec[1] = '{8'd1, 1, 16'h0100, 16'h001D, 16'h0100, 16'h010B, 48'h010E_010D_010C, 1'b0};
    vec[2] = '{8'd0, 1, 16'h0200, 16'h0005, 16'h0200, 16'h020B, 48'h020E_020D_020C, 1'b1};
    vec[3] = '{8'd3, 3, 16'h0300, 16'h0006, 16'h0318, 16'h0323, 48'h0326_0325_0324, 1'b0};

    repeat (3) tick();
    chk("reset fill", 64'(fill_A), 64'd0);
    chk("reset dout", 64'(txn_dout_A[63:0]), 64'd0);
    chk("reset flags", 64'({overflow_A, underrun_A, late_A, seq_err_A, wr_full_A}), 64'd0);
    reset_n = 1'b1;
    tick();

    for (int r = 0; r < 4; r++) begin
      pulse_clr();
      run_frame(vec[r], $sformatf("row%0d", r));
    end

    // Underrun with 11 words buffered.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    nsamps_A = 8'd1;
    for (int i = 0; i < 11; i++) write_word(16'h0A00 + 16'(i));
    request(lat, dout);
    chk("underrun latency", 64'(lat), 64'd1);
    chk("underrun dout", 64'(dout[63:0]), 64'd0);
    chk("underrun flag", 64'(underrun_A), 64'd1);
    chk("underrun fill", 64'(fill_A), 64'd11);

    // Late strobe while a set is being read.
    for (int i = 0; i < 4; i++) write_word(16'h0B00 + 16'(i));
    write_word(16'h0000);
    v0 = valid_cnt;
    fd0 = fd_cnt;
    tx_avail_A = 1'b1; tick(); tx_avail_A = 1'b0;
    tick(); tick();
    tx_avail_A = 1'b1; tick(); tx_avail_A = 1'b0;
    repeat (40) tick();
    chk("late flag", 64'(late_A), 64'd1);
    chk("late valid count", 64'(valid_cnt - v0), 64'd1);
    chk("late frame_done", 64'(fd_cnt - fd0), 64'd1);
    pulse_clr();
    chk("clr flags", 64'({overflow_A, underrun_A, late_A, seq_err_A}), 64'd0);

    // Overflow: DEPTH+1 writes, then a read with one overlapping write.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    nsamps_A = 8'd2;
    wr_A = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_din_A = 16'(i);
      tick();
    end
    wr_A = 1'b0;
    tick();
    chk("full flag", 64'(wr_full_A), 64'd1);
    chk("overflow flag", 64'(overflow_A), 64'd1);
    chk("full fill", 64'(fill_A), 64'(DEPTH));
    tx_avail_A = 1'b1; tick(); tx_avail_A = 1'b0;
    tick();
    wr_A = 1'b1; wr_din_A = 16'hBEEF; tick(); wr_A = 1'b0;
    repeat (20) tick();
    chk("fill after read+write", 64'(fill_A), 64'(DEPTH - 11));
    chk("not full", 64'(wr_full_A), 64'd0);

    // Reset in the middle of a set, then a clean frame.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    nsamps_A = 8'd2;
    for (int i = 0; i < 28; i++) write_word(16'h0C00 + 16'(i));
    tx_avail_A = 1'b1; tick(); tx_avail_A = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midreset fill", 64'(fill_A), 64'd0);
    chk("midreset dout", 64'(txn_dout_A[63:0]), 64'd0);
    chk("midreset outs", 64'({txn_valid_A, frame_done_A, buf_ctr_A, ticks_A[31:0]}), 64'd0);
    tick(); reset_n = 1'b1; tick();
    run_frame('{8'd1, 1, 16'h0400, 16'h0000, 16'h0400, 16'h040B, 48'h040E_040D_040C, 1'b0},
              "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
